handle_pool_allocator: RTL and testbench

//  Hardware allocator that issues and reclaims resource handles: the allocator side that a leak checker audits.

---
 rtl/handle_pool_if.sv | 24 ++
 rtl/handle_pool_allocator.sv | 109 ++++++++++
 tb/tb_handle_pool_allocator.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/handle_pool_if.sv
// handle_pool_if: request/response and status signals between clients and the handle allocator.
interface handle_pool_if #(
  parameter int NUM_HANDLES = 8,
  parameter int ID_W = $clog2(NUM_HANDLES) + 1
);
  logic alloc_req, alloc_type, alloc_gnt, alloc_fail;
  logic [ID_W-1:0] alloc_id;
  logic free_req, free_ok, free_err;
  logic [ID_W-1:0] free_id;
  logic [ID_W-1:0] outstanding, open_file, open_net, peak_used;
  logic audit_req, audit_busy, audit_done;
  logic [ID_W-1:0] leak_count, leak_file, leak_net;
  logic [NUM_HANDLES-1:0] leak_mask;
  modport master (
    output alloc_req, alloc_type, free_req, free_id, audit_req,
    input alloc_gnt, alloc_fail, alloc_id, free_ok, free_err, outstanding, open_file, open_net,
          peak_used, audit_busy, audit_done, leak_count, leak_file, leak_net, leak_mask
  );
  modport slave (
    input alloc_req, alloc_type, free_req, free_id, audit_req,
    output alloc_gnt, alloc_fail, alloc_id, free_ok, free_err, outstanding, open_file, open_net,
           peak_used, audit_busy, audit_done, leak_count, leak_file, leak_net, leak_mask
  );
endinterface

// File: rtl/handle_pool_allocator.sv
// handle_pool_allocator: lowest-free handle allocator with type tracking, free checking and a serial leak audit.
module handle_pool_allocator #(
  parameter int NUM_HANDLES = 8,
  parameter int ID_W = $clog2(NUM_HANDLES) + 1
) (
  input logic clk,
  input logic rst_n,
  handle_pool_if.slave bus
);
  localparam int IW = $clog2(NUM_HANDLES);
  localparam int P = 1 << IW;
  typedef enum logic [1:0] {IDLE, SCAN, DONE} st_t;
  st_t st_q, st_n;
  logic [NUM_HANDLES-1:0] in_use, is_net, use_n, net_n, snap_use, snap_net;
  logic [P-1:0] use_p, net_p;
  logic [IW-1:0] k, fidx, idx;
  logic has_free, gnt, fok;
  logic [ID_W-1:0] out_n, file_n, netc_n, t_file, t_net;
  // pad bitmaps to a power of two so an out-of-range free_id never indexes past the end
  assign use_p = P'(in_use);
  assign net_p = P'(is_net);
  assign fidx = bus.free_id[IW-1:0];
  assign gnt = bus.alloc_req & has_free;
  assign fok = bus.free_req & (bus.free_id < ID_W'(NUM_HANDLES)) & use_p[fidx];
  assign out_n = bus.outstanding + ID_W'(gnt) - ID_W'(fok);
  assign file_n = bus.open_file + ID_W'(gnt & ~bus.alloc_type) - ID_W'(fok & ~net_p[fidx]);
  assign netc_n = bus.open_net + ID_W'(gnt & bus.alloc_type) - ID_W'(fok & net_p[fidx]);
  assign bus.audit_busy = st_q != IDLE;
  always_comb begin
    k = '0;
    has_free = 1'b0;
    for (int i = NUM_HANDLES - 1; i >= 0; i--)
      if (!in_use[i]) begin
        k = IW'(i);
        has_free = 1'b1;
      end
  end
  always_comb begin
    use_n = in_use;
    net_n = is_net;
    if (gnt) begin
      use_n[k] = 1'b1;
      net_n[k] = bus.alloc_type;
    end
    if (fok) use_n[fidx] = 1'b0;
  end
  always_comb begin
    st_n = st_q;
    st_n = st_q == IDLE ? (bus.audit_req ? SCAN : IDLE) :
           st_q == SCAN ? (idx == IW'(NUM_HANDLES - 1) ? DONE : SCAN) : IDLE;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      st_q <= IDLE;
      in_use <= '0;
      is_net <= '0;
      snap_use <= '0;
      snap_net <= '0;
      idx <= '0;
      t_file <= '0;
      t_net <= '0;
      bus.alloc_gnt <= 1'b0;
      bus.alloc_fail <= 1'b0;
      bus.alloc_id <= '0;
      bus.free_ok <= 1'b0;
      bus.free_err <= 1'b0;
      bus.outstanding <= '0;
      bus.open_file <= '0;
      bus.open_net <= '0;
      bus.peak_used <= '0;
      bus.audit_done <= 1'b0;
      bus.leak_count <= '0;
      bus.leak_file <= '0;
      bus.leak_net <= '0;
      bus.leak_mask <= '0;
    end else begin
      st_q <= st_n;
      in_use <= use_n;
      is_net <= net_n;
      bus.alloc_gnt <= gnt;
      bus.alloc_fail <= bus.alloc_req & ~has_free;
      bus.alloc_id <= gnt ? ID_W'(k) : '0;
      bus.free_ok <= fok;
      bus.free_err <= bus.free_req & ~fok;
      bus.outstanding <= out_n;
      bus.open_file <= file_n;
      bus.open_net <= netc_n;
      bus.peak_used <= out_n > bus.peak_used ? out_n : bus.peak_used;
      bus.audit_done <= st_q == DONE;
      if (st_q == IDLE && bus.audit_req) begin
        snap_use <= in_use;
        snap_net <= is_net;
        idx <= '0;
        t_file <= '0;
        t_net <= '0;
      end
      if (st_q == SCAN) begin
        t_file <= t_file + ID_W'(snap_use[idx] & ~snap_net[idx]);
        t_net <= t_net + ID_W'(snap_use[idx] & snap_net[idx]);
        idx <= idx + 1'b1;
      end
      if (st_q == DONE) begin
        bus.leak_file <= t_file;
        bus.leak_net <= t_net;
        bus.leak_count <= t_file + t_net;
        bus.leak_mask <= snap_use;
      end
    end
endmodule

// File: tb/tb_handle_pool_allocator.sv
// tb_handle_pool_allocator: directed stimulus checked every cycle against a set-level model of the pool and audit.
module tb_handle_pool_allocator;
  localparam int N = 8;
  localparam int W = $clog2(N) + 1;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_chk = 0;
  int n_pass = 0;
  int got;
  handle_pool_if #(.NUM_HANDLES(N), .ID_W(W)) bus ();
  handle_pool_allocator #(.NUM_HANDLES(N), .ID_W(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;

  bit m_use[N], m_net[N], s_use[N], s_net[N];
  int m_peak, m_cd, m_k, e_id, e_lc, e_lf, e_ln, e_mask;
  bit e_gnt, e_fail, e_fok, e_ferr, e_done, m_fv;

  function automatic int count(input int sel, input bit use_a[N], input bit net_a[N]);
    int c = 0;
    for (int i = 0; i < N; i++)
      if (use_a[i] && (sel == 0 || (sel == 1 && !net_a[i]) || (sel == 2 && net_a[i]))) c++;
    return c;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
  endtask

  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      for (int i = 0; i < N; i++) begin
        m_use[i] = 0; m_net[i] = 0; s_use[i] = 0; s_net[i] = 0;
      end
      m_peak = 0; m_cd = 0; e_id = 0; e_lc = 0; e_lf = 0; e_ln = 0; e_mask = 0;
      e_gnt = 0; e_fail = 0; e_fok = 0; e_ferr = 0; e_done = 0;
    end else begin
      e_done = 0;
      if (m_cd > 0) begin
        m_cd--;
        if (m_cd == 0) begin
          e_done = 1;
          e_lf = count(1, s_use, s_net);
          e_ln = count(2, s_use, s_net);
          e_lc = count(0, s_use, s_net);
          e_mask = 0;
          for (int i = 0; i < N; i++) if (s_use[i]) e_mask |= 1 << i;
        end
      end else if (bus.alloc_req === 1'b1 && 0) begin
      end else if (bus.audit_req) begin
        s_use = m_use; s_net = m_net; m_cd = N + 1;
      end
      m_k = -1;
      for (int i = N - 1; i >= 0; i--) if (!m_use[i]) m_k = i;
      m_fv = bus.free_req && int'(bus.free_id) < N && m_use[int'(bus.free_id) % N];
      e_gnt = bus.alloc_req && m_k >= 0;
      e_fail = bus.alloc_req && m_k < 0;
      e_fok = m_fv;
      e_ferr = bus.free_req && !m_fv;
      if (m_fv) m_use[int'(bus.free_id)] = 0;
      if (e_gnt) begin
        m_use[m_k] = 1; m_net[m_k] = bus.alloc_type; e_id = m_k;
      end
      if (count(0, m_use, m_net) > m_peak) m_peak = count(0, m_use, m_net);
    end

  always @(negedge clk) begin
    chk("alloc_gnt", bus.alloc_gnt, e_gnt);
    chk("alloc_fail", bus.alloc_fail, e_fail);
    if (e_gnt) chk("alloc_id", bus.alloc_id, e_id);
    chk("free_ok", bus.free_ok, e_fok);
    chk("free_err", bus.free_err, e_ferr);
    chk("outstanding", bus.outstanding, count(0, m_use, m_net));
    chk("open_file", bus.open_file, count(1, m_use, m_net));
    chk("open_net", bus.open_net, count(2, m_use, m_net));
    chk("peak_used", bus.peak_used, m_peak);
    chk("audit_busy", bus.audit_busy, m_cd > 0);
    chk("audit_done", bus.audit_done, e_done);
    chk("leak_count", bus.leak_count, e_lc);
    chk("leak_file", bus.leak_file, e_lf);
    chk("leak_net", bus.leak_net, e_ln);
    chk("leak_mask", bus.leak_mask, e_mask);
  end

  task automatic cyc(input bit ar, input bit at, input bit fr, input int fid, input bit au);
    bus.alloc_req = ar; bus.alloc_type = at; bus.free_req = fr; bus.free_id = W'(fid); bus.audit_req = au;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input int first_alloc);
    got = 0;
    for (int n = 1; n <= 20; n++) begin
      cyc(n == 1 && first_alloc != 0, 0, 0, 0, 0);
      if (bus.audit_done) begin
        got = n;
        break;
      end
    end
    chk("audit_latency", got, N + 1);
  endtask

  initial begin
    bus.alloc_req = 0; bus.alloc_type = 0; bus.free_req = 0; bus.free_id = '0; bus.audit_req = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    cyc(0, 0, 0, 0, 0);
    chk("reset_outstanding", bus.outstanding, 0);
    cyc(1, 0, 0, 0, 0); chk("t1_id0", bus.alloc_id, 0);
    cyc(1, 0, 0, 0, 0); chk("t1_id1", bus.alloc_id, 1);
    cyc(1, 1, 0, 0, 0); chk("t1_id2", bus.alloc_id, 2);
    chk("t1_outstanding", bus.outstanding, 3);
    chk("t1_open_file", bus.open_file, 2);
    chk("t1_open_net", bus.open_net, 1);
    chk("t1_peak", bus.peak_used, 3);
    for (int i = 0; i < 3; i++) begin
      cyc(0, 0, 1, i, 0);
      chk("t2_free_ok", bus.free_ok, 1);
    end
    cyc(0, 0, 0, 0, 1);
    wait_done(0);
    chk("t2_leak_count", bus.leak_count, 0);
    chk("t2_leak_mask", bus.leak_mask, 0);
    cyc(1, 0, 0, 0, 0); chk("t3_id0", bus.alloc_id, 0);
    cyc(1, 1, 0, 0, 0); chk("t3_id1", bus.alloc_id, 1);
    cyc(0, 0, 1, 0, 0);
    cyc(0, 0, 0, 0, 1);
    wait_done(1);
    chk("t3_leak_count", bus.leak_count, 1);
    chk("t3_leak_net", bus.leak_net, 1);
    chk("t3_leak_file", bus.leak_file, 0);
    chk("t3_leak_mask", bus.leak_mask, 8'b0000_0010);
    cyc(0, 0, 1, 0, 0);
    cyc(0, 0, 1, 1, 0);
    for (int i = 0; i < N; i++) begin
      cyc(1, i[0], 0, 0, 0);
      chk("t4_gnt_id", bus.alloc_gnt ? int'(bus.alloc_id) : -1, i);
    end
    cyc(1, 0, 0, 0, 0);
    chk("t4_fail", bus.alloc_fail, 1);
    chk("t4_outstanding", bus.outstanding, 8);
    chk("t4_peak", bus.peak_used, 8);
    cyc(0, 0, 1, 3, 0); chk("t5_free_ok", bus.free_ok, 1);
    cyc(0, 0, 1, 3, 0); chk("t5_double_free", bus.free_err, 1);
    cyc(0, 0, 1, 9, 0); chk("t5_range_free", bus.free_err, 1);
    cyc(0, 0, 1, 8, 0); chk("t5_edge_free", bus.free_err, 1);
    chk("t5_outstanding", bus.outstanding, 7);
    cyc(1, 1, 0, 0, 0); chk("t6_refill_id", bus.alloc_id, 3);
    cyc(1, 0, 1, 0, 0);
    chk("t6_free_ok", bus.free_ok, 1);
    chk("t6_alloc_fail", bus.alloc_fail, 1);
    chk("t6_outstanding", bus.outstanding, 7);
    cyc(1, 0, 0, 0, 0);
    chk("t6_next_id", bus.alloc_gnt ? int'(bus.alloc_id) : -1, 0);
    cyc(0, 0, 0, 0, 1);
    repeat (3) cyc(0, 0, 0, 0, 0);
    chk("t6_busy_before_rst", bus.audit_busy, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rst_busy", bus.audit_busy, 0);
    chk("t6_rst_leak_count", bus.leak_count, 0);
    chk("t6_rst_outstanding", bus.outstanding, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (N + 3) cyc(0, 0, 0, 0, 0);
    chk("t6_post_done", bus.audit_done, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
